main_mem_responder: RTL and testbench

- Memory-side responder for the memsys main-memory interface; the opposite end of the mem_valid_o/mem_ready_i/mem_addr_o/mem_we_o/mem_wdata_o request and mem_valid_i/mem_data_i response path.
- Accepts one block-beat request at a time, holds data in an internal array, and returns read data after a fixed, programmable latency.
- Used as the synthesizable/simulation main memory behind memsys_top in system-level benches.

---
 rtl/main_mem_responder_if.sv | 32 +++
 rtl/main_mem_responder.sv | 121 ++++++++++++
 tb/tb_main_mem_responder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if: request/response bundle between memsys (master) and
// the main-memory responder (slave).
//   valid_i/ready_o    request handshake, accepted when both are high
//   we_i               1 = write, 0 = read
//   addr_i             32-bit byte address
//   wdata_i            write beat (dma_data_width_p*32 bits)
//   valid_o            one-cycle read-response pulse, no backpressure
//   rdata_o            read beat, meaningful while valid_o=1
// Signal names are from the responder's point of view.
interface main_mem_responder_if #(
  parameter int dma_data_width_p = 4
);
  localparam int data_w = dma_data_width_p * 32;

  logic              valid_i;
  logic              ready_o;
  logic              we_i;
  logic [31:0]       addr_i;
  logic [data_w-1:0] wdata_i;
  logic              valid_o;
  logic [data_w-1:0] rdata_o;

  modport master (
    output valid_i, we_i, addr_i, wdata_i,
    input  ready_o, valid_o, rdata_o
  );

  modport slave (
    input  valid_i, we_i, addr_i, wdata_i,
    output ready_o, valid_o, rdata_o
  );
endinterface

// File: rtl/main_mem_responder.sv
// main_mem_responder: memory-side responder for the memsys main-memory port.
// Accepts one beat request at a time, stores beats in an internal array and
// answers reads after a fixed latency of latency_p cycles. Writes occupy the
// port for the same latency but produce no response.
// Ports:
//   clk_i      clock, all state changes on the rising edge
//   nreset_i   asynchronous active-low reset
//   bus        request/response bundle (slave modport)
module main_mem_responder #(
  parameter int dma_data_width_p = 4,
  parameter int mem_words_p      = 1024,
  parameter int latency_p        = 4
) (
  input logic                 clk_i,
  input logic                 nreset_i,
  main_mem_responder_if.slave bus
);

  localparam int         data_w = dma_data_width_p * 32;
  localparam int         off_w  = $clog2(dma_data_width_p * 4);
  localparam int         idx_w  = $clog2(mem_words_p);
  localparam logic [7:0] lat_m1 = 8'(latency_p - 1);

  typedef enum logic {
    st_idle,
    st_busy
  } state_e;

  state_e            state_q, state_n;
  logic [7:0]        cnt_q, cnt_n;
  logic              pend_q, pend_n;
  logic [data_w-1:0] rdata_q, rdata_n;
  logic [data_w-1:0] cap_q;
  logic [data_w-1:0] mem [mem_words_p];

  logic              ready;
  logic              resp;
  logic              accept;
  logic [idx_w-1:0]  idx;

  // Shifting then truncating drops the in-beat byte offset and wraps the
  // address modulo mem_words_p beats.
  assign idx    = idx_w'(bus.addr_i >> off_w);
  // Nothing is accepted while reset is held, even though the state reads IDLE.
  assign accept = bus.valid_i && ready && nreset_i;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pend_q  <= pend_n;
      rdata_q <= rdata_n;
    end
  end

  // Beat storage and read capture. The entry is read at the acceptance edge,
  // so a read issued after a write to the same index sees the new beat.
  // NOTE: the array and its capture register have no reset; contents survive
  // reset, and resetting a RAM would prevent it mapping onto memory macros.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (bus.we_i) begin
        mem[idx] <= bus.wdata_i;
      end else begin
        cap_q <= mem[idx];
      end
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pend_n  = pend_q;
    rdata_n = rdata_q;
    unique case (state_q)
      st_idle: begin
        if (accept) begin
          state_n = st_busy;
          cnt_n   = lat_m1;
          pend_n  = ~bus.we_i;
        end
      end
      st_busy: begin
        if (cnt_q != 8'd0) begin
          cnt_n = cnt_q - 8'd1;
        end else begin
          state_n = st_idle;
          pend_n  = 1'b0;
          // Remember the beat just returned so rdata_o holds it afterwards.
          if (pend_q) begin
            rdata_n = cap_q;
          end
        end
      end
      default: state_n = st_idle;
    endcase
  end

  // Output decode: purely from registered state, never from valid_i.
  always_comb begin
    ready       = (state_q == st_idle);
    resp        = (state_q == st_busy) && (cnt_q == 8'd0) && pend_q;
    bus.ready_o = ready;
    bus.valid_o = resp;
    // The captured beat is shown during the response cycle itself; otherwise
    // the last returned beat is held, untouched by writes.
    bus.rdata_o = resp ? cap_q : rdata_q;
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed stimulus for two responders (latency 4 and
// latency 1). Drivers push expected read responses (cycle, data) into a queue
// per instance; independent monitors pop and compare whenever valid_o is seen.
module tb_main_mem_responder;

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic nreset_i = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  rsp_t q4[$];
  rsp_t q1[$];

  localparam logic [127:0] big_c = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  main_mem_responder_if #(.dma_data_width_p(4)) b4 ();
  main_mem_responder_if #(.dma_data_width_p(4)) b1 ();

  main_mem_responder #(
    .dma_data_width_p(4), .mem_words_p(1024), .latency_p(4)
  ) dut4 (
    .clk_i(clk), .nreset_i(nreset_i), .bus(b4.slave)
  );

  main_mem_responder #(
    .dma_data_width_p(4), .mem_words_p(1024), .latency_p(1)
  ) dut1 (
    .clk_i(clk), .nreset_i(nreset_i), .bus(b1.slave)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
  endtask

  // Issue one request on the latency-4 instance; returns the acceptance cycle.
  task automatic req4(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                      input bit track, input logic [127:0] exp, output int t);
    int n;
    b4.valid_i = 1'b1;
    b4.we_i    = we;
    b4.addr_i  = addr;
    b4.wdata_i = wd;
    n = 0;
    while (b4.ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("req4_ready_timeout");
    t = cyc;
    if (!we && track) q4.push_back('{t + 4, exp});
    @(posedge clk);
    #1;
    b4.valid_i = 1'b0;
    b4.we_i    = 1'bx;
    b4.addr_i  = 'x;
    b4.wdata_i = 'x;
  endtask

  task automatic write1(input logic [31:0] addr, input logic [127:0] wd);
    int n;
    b1.valid_i = 1'b1;
    b1.we_i    = 1'b1;
    b1.addr_i  = addr;
    b1.wdata_i = wd;
    n = 0;
    while (b1.ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("write1_ready_timeout");
    @(posedge clk);
    #1;
    b1.valid_i = 1'b0;
    b1.we_i    = 1'bx;
    b1.addr_i  = 'x;
    b1.wdata_i = 'x;
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (b4.ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("idle4_timeout");
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (b1.ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("idle1_timeout");
  endtask

  // Monitors: every valid_o pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (b4.valid_o !== 1'b0) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp4_unexpected: valid_o=%b with no read outstanding (cycle %0d)", b4.valid_o, cyc);
      end else begin
        rsp_t e;
        e = q4.pop_front();
        check("rsp4_cycle", 128'(cyc), 128'(e.cyc));
        check("rsp4_data", b4.rdata_o, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (b1.valid_o !== 1'b0) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp1_unexpected: valid_o=%b with no read outstanding (cycle %0d)", b1.valid_o, cyc);
      end else begin
        rsp_t e;
        e = q1.pop_front();
        check("rsp1_cycle", 128'(cyc), 128'(e.cyc));
        check("rsp1_data", b1.rdata_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int acc;

    b4.valid_i = 1'b0; b4.we_i = 1'b0; b4.addr_i = '0; b4.wdata_i = '0;
    b1.valid_i = 1'b0; b1.we_i = 1'b0; b1.addr_i = '0; b1.wdata_i = '0;

    // Reset held for 3 cycles, released away from the clock edge.
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset_i = 1'b1;
    @(negedge clk);
    check("rst_ready4", b4.ready_o, 1'b1);
    check("rst_valid4", b4.valid_o, 1'b0);
    check("rst_rdata4", b4.rdata_o, '0);
    check("rst_ready1", b1.ready_o, 1'b1);
    check("rst_valid1", b1.valid_o, 1'b0);
    check("rst_rdata1", b1.rdata_o, '0);

    // Write then read 0x40: port busy for exactly 4 cycles after each accept.
    req4(1'b1, 32'h40, big_c, 1'b0, '0, t);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("wr_busy_ready", b4.ready_o, 1'b0);
    end
    @(negedge clk);
    check("wr_done_ready", b4.ready_o, 1'b1);
    req4(1'b0, 32'h40, '0, 1'b1, big_c, t);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("rd_busy_ready", b4.ready_o, 1'b0);
    end
    @(negedge clk);
    check("rd_done_ready", b4.ready_o, 1'b1);

    // A write must not disturb the held read beat.
    req4(1'b1, 32'h0, 128'h11, 1'b0, '0, t);
    wait_idle4();
    check("rdata_hold_after_write", b4.rdata_o, big_c);

    // In-beat offset ignored; upper address bits wrap (1024 beats x 16 B).
    req4(1'b0, 32'h0000_000C, '0, 1'b1, 128'h11, t);
    req4(1'b0, 32'h0000_4000, '0, 1'b1, 128'h11, t);

    // Valid held high across BUSY: only cycles with ready_o=1 accept.
    req4(1'b1, 32'h80, 128'hA5A5_0080, 1'b0, '0, t);
    wait_idle4();
    b4.valid_i = 1'b1;
    b4.we_i    = 1'b0;
    b4.addr_i  = 32'h80;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (b4.ready_o === 1'b1) begin
        acc++;
        q4.push_back('{cyc + 4, 128'hA5A5_0080});
      end
      @(posedge clk);
      #1;
    end
    b4.valid_i = 1'b0;
    check("busy_accept_count", 128'(acc), 128'd3);

    // Latency 1: back-to-back reads, ready pattern 1,0,1,0.
    write1(32'h0, 128'h1111);
    write1(32'h10, 128'h2222);
    wait_idle1();
    b1.valid_i = 1'b1;
    b1.we_i    = 1'b0;
    b1.addr_i  = 32'h0;
    check("b2b_ready_t0", b1.ready_o, 1'b1);
    t = cyc;
    q1.push_back('{t + 1, 128'h1111});
    q1.push_back('{t + 3, 128'h2222});
    @(posedge clk);
    #1;
    b1.addr_i = 32'h10;
    check("b2b_ready_t1", b1.ready_o, 1'b0);
    @(posedge clk);
    #1;
    check("b2b_ready_t2", b1.ready_o, 1'b1);
    @(posedge clk);
    #1;
    b1.valid_i = 1'b0;
    check("b2b_ready_t3", b1.ready_o, 1'b0);

    // Reset two cycles into a read: no response, prior write stays readable.
    wait_idle4();
    req4(1'b1, 32'h200, 128'h77, 1'b0, '0, t);
    req4(1'b0, 32'h80, '0, 1'b0, '0, t);
    @(posedge clk);
    #1;
    nreset_i = 1'b0;
    #1;
    check("midrst_ready", b4.ready_o, 1'b1);
    check("midrst_valid", b4.valid_o, 1'b0);
    repeat (2) @(negedge clk);
    nreset_i = 1'b1;
    @(negedge clk);
    check("postrst_ready", b4.ready_o, 1'b1);
    check("postrst_rdata", b4.rdata_o, '0);
    repeat (6) @(negedge clk);
    req4(1'b0, 32'h200, '0, 1'b1, 128'h77, t);
    req4(1'b0, 32'h40, '0, 1'b1, big_c, t);

    repeat (10) @(negedge clk);
    check("q4_drained", 128'(q4.size()), 128'd0);
    check("q1_drained", 128'(q1.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
